// File: rtl/space_inv_pkg.sv
// rtl/space_inv_pkg.sv - shared march-state type and screen geometry for the invader blocks
//
// Purpose : types and constants shared by the fleet march controller and the
//           per-enemy sprite blocks.
// Contents: march_state_t       fleet FSM state (IDLE, MARCH, DESCEND, LANDED)
//           SCREEN_LEFT/RIGHT   legal horizontal extent of the fleet box, pixels
//           LAND_Y              fleet bottom edge at or below this row means landed
package space_inv_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MARCH   = 2'd1,
    DESCEND = 2'd2,
    LANDED  = 2'd3
  } march_state_t;

  localparam int SCREEN_LEFT  = 0;
  localparam int SCREEN_RIGHT = 639;
  localparam int LAND_Y       = 420;

endpackage

// File: rtl/march_timer.sv
// rtl/march_timer.sv - frame counter and step cadence for the fleet march
//
// Purpose : counts frame ticks while the fleet is moving and flags the tick on
//           which a step falls due. The step period is fixed at BASE_PERIOD, or,
//           with ENEMY_SPEEDUP_EN defined, shortens by one frame per enemy killed
//           down to MIN_PERIOD.
// Ports   : Clk          in  system clock
//           Reset_n      in  synchronous active-low reset
//           clear        in  restart the count from zero
//           run          in  fleet is marching/descending; ticks are counted
//           frame_tick   in  one-Clk pulse per video frame
//           alive_count  in  enemies alive (only present with ENEMY_SPEEDUP_EN)
//           step_due     out combinational: this tick completes a period
// Macro   : ENEMY_SPEEDUP_EN
module march_timer #(
  parameter int BASE_PERIOD   = 30,
  parameter int MIN_PERIOD    = 2,
  parameter int TOTAL_ENEMIES = 40
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       clear,
  input  logic       run,
  input  logic       frame_tick,
`ifdef ENEMY_SPEEDUP_EN
  input  logic [5:0] alive_count,
`endif
  output logic       step_due
);

  logic [7:0] frame_cnt;
  logic [7:0] period;

`ifdef ENEMY_SPEEDUP_EN
  logic [7:0] killed;

  // alive_count above TOTAL_ENEMIES is treated as a full fleet.
  always_comb begin
    killed = '0;
    period = 8'(BASE_PERIOD);
    if (alive_count < 6'(TOTAL_ENEMIES))
      killed = 8'(TOTAL_ENEMIES) - {2'b00, alive_count};
    if ({1'b0, killed} + 9'(MIN_PERIOD) >= 9'(BASE_PERIOD))
      period = 8'(MIN_PERIOD);
    else
      period = 8'(BASE_PERIOD) - killed;
  end
`else
  assign period = 8'(BASE_PERIOD);
`endif

  // >= rather than == so that a period shrinking below the running count
  // fires on the next tick instead of waiting for the counter to wrap.
  assign step_due = run && frame_tick && (frame_cnt >= period - 8'd1);

  always_ff @(posedge Clk) begin
    if (!Reset_n || clear)
      frame_cnt <= '0;
    else if (run && frame_tick)
      frame_cnt <= step_due ? 8'd0 : frame_cnt + 8'd1;
  end

endmodule

// File: rtl/enemy_march_ctrl.sv
// rtl/enemy_march_ctrl.sv - fleet-level march controller feeding the enemy sprite blocks
//
// Purpose : moves the fleet bounding box left/right in STEP_X increments, drops it
//           DROP_ROWS x STEP_Y at each screen-edge bounce, and flags landing and
//           wave clear. The sprites apply one step per step_pulse using the
//           shared direction pair.
// Ports   : Clk                in  system clock
//           Reset_n            in  synchronous active-low reset
//           frame_tick         in  one-Clk pulse per video frame
//           start              in  begin a wave (taken in IDLE/LANDED)
//           delete_enemies     in  abort the wave, back to IDLE
//           alive_count[5:0]   in  enemies still alive
//           fleet_init_x[9:0]  in  fleet_x loaded on start
//           fleet_init_y[9:0]  in  fleet_y loaded on start
//           enemy_direction_X  out 0=left, 1=right
//           enemy_direction_Y  out 1=current step is a descend step
//           step_pulse         out one-Clk strobe, apply one step
//           fleet_x[9:0]       out box left edge
//           fleet_y[9:0]       out box top edge
//           fleet_landed       out sticky until start/reset
//           wave_clear         out one-Clk pulse when the fleet is wiped out
//           busy               out fleet in MARCH/DESCEND
// Macro   : ENEMY_SPEEDUP_EN (speed-up with kills, handled in march_timer)
module enemy_march_ctrl
  import space_inv_pkg::*;
#(
  parameter int STEP_X        = 2,
  parameter int STEP_Y        = 8,
  parameter int DROP_ROWS     = 1,
  parameter int FLEET_W       = 400,
  parameter int FLEET_H       = 200,
  parameter int BASE_PERIOD   = 30,
  parameter int MIN_PERIOD    = 2,
  parameter int TOTAL_ENEMIES = 40
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       delete_enemies,
  input  logic [5:0] alive_count,
  input  logic [9:0] fleet_init_x,
  input  logic [9:0] fleet_init_y,
  output logic       enemy_direction_X,
  output logic       enemy_direction_Y,
  output logic       step_pulse,
  output logic [9:0] fleet_x,
  output logic [9:0] fleet_y,
  output logic       fleet_landed,
  output logic       wave_clear,
  output logic       busy
);

  march_state_t state, nxt_state;
  logic [7:0]   drop_cnt, nxt_drop_cnt;
  logic [9:0]   nxt_x, nxt_y;
  logic         nxt_dir_x, nxt_dir_y, nxt_pulse, nxt_landed, nxt_wave_clear;
  logic         timer_clear;
  logic         step_due;

  logic [10:0]  right_probe;
  logic [10:0]  y_sum;
  logic [9:0]   y_step;
  logic [10:0]  land_probe;
  logic         at_edge;
  logic         landing;

  assign busy = (state == MARCH) || (state == DESCEND);

  march_timer #(
    .BASE_PERIOD  (BASE_PERIOD),
    .MIN_PERIOD   (MIN_PERIOD),
    .TOTAL_ENEMIES(TOTAL_ENEMIES)
  ) u_timer (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .clear      (timer_clear),
    .run        (busy),
    .frame_tick (frame_tick),
`ifdef ENEMY_SPEEDUP_EN
    .alive_count(alive_count),
`endif
    .step_due   (step_due)
  );

  // Edge and landing compares run in 11 bits so box extents past 1023 cannot wrap.
  assign right_probe = {1'b0, fleet_x} + 11'(FLEET_W - 1 + STEP_X);
  assign at_edge     = enemy_direction_X ? (right_probe > 11'(SCREEN_RIGHT))
                                         : ({1'b0, fleet_x} < 11'(SCREEN_LEFT + STEP_X));
  assign y_sum       = {1'b0, fleet_y} + 11'(STEP_Y);
  assign y_step      = y_sum[10] ? 10'h3FF : y_sum[9:0];
  assign land_probe  = {1'b0, y_step} + 11'(FLEET_H);
  assign landing     = land_probe >= 11'(LAND_Y);

  always_comb begin
    nxt_state      = state;
    nxt_x          = fleet_x;
    nxt_y          = fleet_y;
    nxt_dir_x      = enemy_direction_X;
    nxt_dir_y      = enemy_direction_Y;
    nxt_drop_cnt   = drop_cnt;
    nxt_landed     = fleet_landed;
    nxt_pulse      = 1'b0;
    nxt_wave_clear = 1'b0;
    timer_clear    = 1'b0;

    if (delete_enemies) begin
      nxt_state   = IDLE;
      timer_clear = 1'b1;
    end else if (busy && (alive_count == 6'd0)) begin
      nxt_wave_clear = 1'b1;
      nxt_state      = IDLE;
      timer_clear    = 1'b1;
    end else if (((state == IDLE) || (state == LANDED)) && start) begin
      nxt_x       = fleet_init_x;
      nxt_y       = fleet_init_y;
      nxt_dir_x   = 1'b1;
      nxt_dir_y   = 1'b0;
      nxt_landed  = 1'b0;
      nxt_state   = MARCH;
      timer_clear = 1'b1;
    end else if (busy && step_due) begin
      case (state)
        MARCH: begin
          if (at_edge) begin
            // Bounce step: no pulse; descent starts on the following period.
            nxt_dir_y    = 1'b1;
            nxt_drop_cnt = '0;
            nxt_state    = DESCEND;
          end else begin
            nxt_x     = enemy_direction_X ? fleet_x + 10'(STEP_X) : fleet_x - 10'(STEP_X);
            nxt_dir_y = 1'b0;
            nxt_pulse = 1'b1;
          end
        end
        DESCEND: begin
          nxt_y        = y_step;
          nxt_dir_y    = 1'b1;
          nxt_pulse    = 1'b1;
          nxt_drop_cnt = drop_cnt + 8'd1;
          if (landing) begin
            nxt_landed = 1'b1;
            nxt_state  = LANDED;
          end else if (drop_cnt == 8'(DROP_ROWS - 1)) begin
            // dir_Y stays 1 through this pulse; the next march step clears it.
            nxt_dir_x = ~enemy_direction_X;
            nxt_state = MARCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      state             <= IDLE;
      drop_cnt          <= '0;
      fleet_x           <= '0;
      fleet_y           <= '0;
      enemy_direction_X <= 1'b1;
      enemy_direction_Y <= 1'b0;
      step_pulse        <= 1'b0;
      fleet_landed      <= 1'b0;
      wave_clear        <= 1'b0;
    end else begin
      state             <= nxt_state;
      drop_cnt          <= nxt_drop_cnt;
      fleet_x           <= nxt_x;
      fleet_y           <= nxt_y;
      enemy_direction_X <= nxt_dir_x;
      enemy_direction_Y <= nxt_dir_y;
      step_pulse        <= nxt_pulse;
      fleet_landed      <= nxt_landed;
      wave_clear        <= nxt_wave_clear;
    end
  end

endmodule

// File: tb/tb_enemy_march_ctrl.sv
// tb/tb_enemy_march_ctrl.sv - scoreboard bench for enemy_march_ctrl (default build)
module tb_enemy_march_ctrl;

  localparam int FW = 400, FH = 200, SX = 2, SY = 8, SR = 639, SL = 0;
  localparam int LY = 420, PER = 30, DROPS = 1;
  localparam int M_IDLE = 0, M_MARCH = 1, M_DESC = 2, M_LANDED = 3;

  logic       Clk = 1'b0;
  logic       Reset_n = 1'b0;
  logic       frame_tick = 1'b0, start = 1'b0, delete_enemies = 1'b0;
  logic [5:0] alive_count = 6'd40;
  logic [9:0] fleet_init_x = '0, fleet_init_y = '0;
  logic       enemy_direction_X, enemy_direction_Y, step_pulse;
  logic [9:0] fleet_x, fleet_y;
  logic       fleet_landed, wave_clear, busy;

  enemy_march_ctrl dut (
    .Clk(Clk), .Reset_n(Reset_n), .frame_tick(frame_tick), .start(start),
    .delete_enemies(delete_enemies), .alive_count(alive_count),
    .fleet_init_x(fleet_init_x), .fleet_init_y(fleet_init_y),
    .enemy_direction_X(enemy_direction_X), .enemy_direction_Y(enemy_direction_Y),
    .step_pulse(step_pulse), .fleet_x(fleet_x), .fleet_y(fleet_y),
    .fleet_landed(fleet_landed), .wave_clear(wave_clear), .busy(busy)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad = 0;

  typedef struct {
    bit is_wc;
    int x;
    int y;
    bit dx;
    bit dy;
  } ev_t;
  ev_t exp_q[$];
  ev_t mon_e;
  bit  mon_en = 1'b0;

  // Reference model: fleet position/heading in plain integers.
  int m_mode, m_x, m_y, m_frames, m_drops;
  bit m_dx, m_dy, m_landed;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_x = 0; m_y = 0; m_frames = 0; m_drops = 0;
    m_dx = 1'b1; m_dy = 1'b0; m_landed = 1'b0;
  endtask

  task automatic push_step();
    ev_t e;
    e.is_wc = 1'b0; e.x = m_x; e.y = m_y; e.dx = m_dx; e.dy = m_dy;
    exp_q.push_back(e);
  endtask

  task automatic model_step();
    if (m_mode == M_MARCH) begin
      if ((m_dx && (m_x + FW - 1 + SX > SR)) || (!m_dx && (m_x - SX < SL))) begin
        m_mode = M_DESC; m_dy = 1'b1; m_drops = 0;
      end else begin
        m_x = m_dx ? m_x + SX : m_x - SX;
        m_dy = 1'b0;
        push_step();
      end
    end else begin
      m_y = (m_y + SY > 1023) ? 1023 : m_y + SY;
      m_dy = 1'b1;
      m_drops++;
      if (m_y + FH >= LY) begin
        m_landed = 1'b1; m_mode = M_LANDED;
      end else if (m_drops == DROPS) begin
        m_dx = !m_dx; m_mode = M_MARCH;
      end
      push_step();
    end
  endtask

  task automatic model_edge(input bit tick, input bit st, input bit del,
                            input int alive, input int ix, input int iy);
    ev_t e;
    bit  moving;
    moving = (m_mode == M_MARCH) || (m_mode == M_DESC);
    if (del) begin
      m_mode = M_IDLE; m_frames = 0;
    end else if (moving && alive == 0) begin
      e.is_wc = 1'b1; e.x = 0; e.y = 0; e.dx = 1'b0; e.dy = 1'b0;
      exp_q.push_back(e);
      m_mode = M_IDLE;
    end else if ((m_mode == M_IDLE || m_mode == M_LANDED) && st) begin
      m_x = ix; m_y = iy; m_dx = 1'b1; m_dy = 1'b0; m_landed = 1'b0;
      m_frames = 0; m_mode = M_MARCH;
    end else if (moving && tick) begin
      m_frames++;
      if (m_frames == PER) begin
        m_frames = 0;
        model_step();
      end
    end
  endtask

  task automatic drive(input bit tick, input bit st, input bit del,
                       input int alive, input int ix, input int iy);
    frame_tick = tick; start = st; delete_enemies = del;
    alive_count = 6'(alive); fleet_init_x = 10'(ix); fleet_init_y = 10'(iy);
    model_edge(tick, st, del, alive, ix, iy);
    @(posedge Clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 40, 0, 0);
  endtask

  task automatic check_state(input string tag);
    check({tag, "_fleet_x"}, int'(fleet_x), m_x);
    check({tag, "_fleet_y"}, int'(fleet_y), m_y);
    check({tag, "_dir_x"}, int'(enemy_direction_X), int'(m_dx));
    check({tag, "_dir_y"}, int'(enemy_direction_Y), int'(m_dy));
    check({tag, "_busy"}, int'(busy), int'(m_mode == M_MARCH || m_mode == M_DESC));
    check({tag, "_landed"}, int'(fleet_landed), int'(m_landed));
  endtask

  // Monitor: every strobe the DUT raises must match the next expected event.
  always @(negedge Clk) begin
    if (mon_en && (step_pulse || wave_clear)) begin
      if (exp_q.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_event: step_pulse=%0b wave_clear=%0b, expected none (t=%0t)",
                 step_pulse, wave_clear, $time);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind_wave_clear", int'(wave_clear), int'(mon_e.is_wc));
        check("event_kind_step", int'(step_pulse), int'(!mon_e.is_wc));
        if (!mon_e.is_wc) begin
          check("pulse_fleet_x", int'(fleet_x), mon_e.x);
          check("pulse_fleet_y", int'(fleet_y), mon_e.y);
          check("pulse_dir_x", int'(enemy_direction_X), int'(mon_e.dx));
          check("pulse_dir_y", int'(enemy_direction_Y), int'(mon_e.dy));
        end else begin
          check("wave_clear_busy", int'(busy), 0);
        end
      end
    end
  end

  initial begin
    int rx, ry, alive;
    bit tk, st, del;

    // Reset held for two cycles.
    model_reset();
    Reset_n = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    check("rst_dir_x", int'(enemy_direction_X), 1);
    check("rst_dir_y", int'(enemy_direction_Y), 0);
    check("rst_step_pulse", int'(step_pulse), 0);
    check("rst_wave_clear", int'(wave_clear), 0);
    check_state("rst");
    Reset_n = 1'b1;
    mon_en = 1'b1;

    // First step lands one Clk after the 30th tick.
    drive(1'b0, 1'b1, 1'b0, 40, 100, 50);
    check_state("start");
    ticks(29);
    check("no_step_before_30", int'(fleet_x), 100);
    ticks(1);
    check("step_latency_pulse", int'(step_pulse), 1);
    check_state("first_step");
    drive(1'b0, 1'b0, 1'b0, 40, 0, 0);

    // Right-edge bounce, descend, turn left.
    drive(1'b0, 1'b0, 1'b1, 40, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 40, 240, 0);
    ticks(30);
    check("bounce_no_pulse", int'(step_pulse), 0);
    check_state("bounce");
    ticks(30);
    check_state("descend");
    ticks(30);
    check_state("march_left");

    // Descent into the landing row.
    drive(1'b0, 1'b0, 1'b1, 40, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 40, 240, 212);
    ticks(60);
    check_state("landed");
    ticks(90);
    check_state("landed_hold");
    drive(1'b0, 1'b1, 1'b0, 40, 200, 0);
    check_state("rearm");

    // Fleet wiped out while marching.
    ticks(10);
    drive(1'b1, 1'b0, 1'b0, 0, 0, 0);
    check_state("wave_clear");
    drive(1'b0, 1'b0, 1'b0, 40, 0, 0);

    // Abort on the very tick a step falls due.
    drive(1'b0, 1'b1, 1'b0, 40, 100, 50);
    ticks(29);
    drive(1'b1, 1'b0, 1'b1, 40, 0, 0);
    check("delete_no_pulse", int'(step_pulse), 0);
    check_state("delete");
    drive(1'b0, 1'b0, 1'b0, 40, 0, 0);

    // Randomized waves with ticks gaps, occasional kills-to-zero and aborts.
    for (int c = 0; c < 25000; c++) begin
      tk = ($urandom_range(0, 3) != 0);
      st = 1'b0; rx = 0; ry = 0;
      if ((m_mode == M_IDLE || m_mode == M_LANDED) && $urandom_range(0, 19) == 0) begin
        st = 1'b1;
        rx = $urandom_range(0, 240);
        ry = $urandom_range(100, 215);
      end
      del = ($urandom_range(0, 2999) == 0);
      alive = ($urandom_range(0, 3999) == 0) ? 0 : $urandom_range(1, 40);
      drive(tk, st, del, alive, rx, ry);
      if (c % 1000 == 999) check_state("rand");
    end

    // Reset in the middle of a march.
    drive(1'b0, 1'b0, 1'b1, 40, 0, 0);
    drive(1'b0, 1'b1, 1'b0, 40, 150, 30);
    ticks(45);
    Reset_n = 1'b0;
    @(posedge Clk);
    #1;
    model_reset();
    Reset_n = 1'b1;
    check_state("mid_reset");
    ticks(40);
    check_state("after_reset");

    drive(1'b0, 1'b0, 1'b0, 40, 0, 0);
    drive(1'b0, 1'b0, 1'b0, 40, 0, 0);
    check("events_outstanding", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
